// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Front end of the accumulator CPU.  Collects the program as a byte stream
// from the UART receiver, pairs the bytes into 16-bit instruction words
// (little-endian: first byte is bits [7:0] and holds the opcode), and writes
// the words into program memory from address 0 upward.  Loading ends when a
// HLT word has been written or when the last memory address has been
// filled.  After that the CPU is released through cpu_en.
//
// Ports
//   clk        : system clock, rising edge
//   Clear      : asynchronous active-high reset
//   rx_data    : received byte, meaningful only while rx_done is high
//   rx_done    : single-cycle strobe marking a new byte on rx_data
//   pm_we      : program memory write enable, one cycle per word
//   pm_addr    : program memory write address
//   pm_wdata   : instruction word being written
//   cpu_en     : high once loading is complete, held until Clear
//   load_done  : one-cycle pulse on the first cycle of DONE
//   overflow   : sticky, memory filled without seeing a HLT word
//   word_count : number of words written so far (0 .. 2^ADDR_W)
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int         ADDR_W     = 11,
    parameter int         DATA_W     = 16,
    parameter logic [4:0] HLT_OPCODE = 5'b00000
) (
    input  logic              clk,
    input  logic              Clear,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              cpu_en,
    output logic              load_done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        LOW   = 2'd0,
        HIGH  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] low_byte;

    // Termination tests for the word currently being written.  A HLT word
    // takes priority over a full memory, so a HLT written into the last
    // address is a clean finish rather than an overflow.
    logic is_hlt;
    logic mem_full;

    always_comb begin
        is_hlt   = (pm_wdata[4:0] == HLT_OPCODE);
        mem_full = (pm_addr == {ADDR_W{1'b1}});
    end

    // Loader FSM with all outputs registered.  pm_we and load_done are
    // pulses: they default low every cycle and are raised only on the
    // transition into WRITE or DONE respectively.  In WRITE a new strobe is
    // taken as the next low byte so a sender running flat out loses nothing;
    // when the word in WRITE ends the load, that byte is simply dropped.
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            state      <= LOW;
            low_byte   <= '0;
            pm_we      <= 1'b0;
            pm_addr    <= '0;
            pm_wdata   <= '0;
            cpu_en     <= 1'b0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            pm_we     <= 1'b0;
            load_done <= 1'b0;

            case (state)
                LOW: begin
                    if (rx_done) begin
                        low_byte <= rx_data;
                        state    <= HIGH;
                    end
                end

                HIGH: begin
                    if (rx_done) begin
                        pm_wdata <= DATA_W'({rx_data, low_byte});
                        pm_we    <= 1'b1;
                        state    <= WRITE;
                    end
                end

                WRITE: begin
                    word_count <= word_count + (ADDR_W+1)'(1);
                    if (is_hlt || mem_full) begin
                        state     <= DONE;
                        cpu_en    <= 1'b1;
                        load_done <= 1'b1;
                        if (!is_hlt) begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        pm_addr <= pm_addr + ADDR_W'(1);
                        if (rx_done) begin
                            low_byte <= rx_data;
                            state    <= HIGH;
                        end else begin
                            state <= LOW;
                        end
                    end
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= LOW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Scoreboard bench for program_loader, built with a small memory (ADDR_W=3)
// so that the memory-full path is reachable with a handful of words.
// Stimulus pushes each expected {address, word} into a queue before sending
// the word's second byte; an independent monitor pops an entry on every
// pm_we pulse and compares it.  A write with no queued entry is a failure,
// which covers every "no write expected" case.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    logic              clk;
    logic              Clear;
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [DATA_W-1:0] pm_wdata;
    logic              cpu_en;
    logic              load_done;
    logic              overflow;
    logic [ADDR_W:0]   word_count;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t expQueue[$];
    int   checks   = 0;
    int   failures = 0;

    program_loader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .HLT_OPCODE (5'b00000)
    ) dut (
        .clk        (clk),
        .Clear      (Clear),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .pm_we      (pm_we),
        .pm_addr    (pm_addr),
        .pm_wdata   (pm_wdata),
        .cpu_en     (cpu_en),
        .load_done  (load_done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point shared by the stimulus thread and the monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write the DUT makes must match the oldest expected one.
    always @(negedge clk) begin
        if (!Clear && pm_we) begin
            if (expQueue.size() == 0) begin
                checkOutput("unexpected_write_addr", 32'(pm_addr), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expQueue.pop_front();
                checkOutput("write_addr", 32'(pm_addr), 32'(e.addr));
                checkOutput("write_data", 32'(pm_wdata), 32'(e.data));
            end
        end
    end

    // Drives one byte strobe; called and returns on a falling edge.
    task automatic sendByte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sends one word as two bytes; queues its expected write when one is due.
    task automatic applyStimulus(input logic [7:0] lo, input logic [7:0] hi,
                                 input logic expectWrite,
                                 input logic [ADDR_W-1:0] addr, input int gap);
        sendByte(lo, gap);
        if (expectWrite) begin
            expQueue.push_back('{addr: addr, data: {hi, lo}});
        end
        sendByte(hi, gap);
    endtask

    task automatic doReset();
        @(negedge clk);
        Clear   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(negedge clk);
        Clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_pm_we"},      32'(pm_we),      0);
        checkOutput({tag, "_pm_addr"},    32'(pm_addr),    0);
        checkOutput({tag, "_pm_wdata"},   32'(pm_wdata),   0);
        checkOutput({tag, "_cpu_en"},     32'(cpu_en),     0);
        checkOutput({tag, "_load_done"},  32'(load_done),  0);
        checkOutput({tag, "_overflow"},   32'(overflow),   0);
        checkOutput({tag, "_word_count"}, 32'(word_count), 0);
    endtask

    // Waits (bounded) for the load_done pulse, then confirms it lasts one
    // cycle and that the final status matches.
    task automatic waitDone(input string tag, input int expCount, input logic expOvf);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (load_done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_load_done_seen"}, 32'(found), 1);
        @(negedge clk);
        checkOutput({tag, "_load_done_width"}, 32'(load_done), 0);
        checkOutput({tag, "_cpu_en"},         32'(cpu_en),     1);
        checkOutput({tag, "_word_count"},     32'(word_count), 32'(expCount));
        checkOutput({tag, "_overflow"},       32'(overflow),   32'(expOvf));
        checkOutput({tag, "_queue_empty"},    32'(expQueue.size()), 0);
    endtask

    initial begin
        Clear   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        Clear = 1'b0;

        // Idle after reset: nothing moves, CPU stays held.
        repeat (100) @(negedge clk);
        checkIdle("reset_idle");

        // Three words with idle gaps, ending with HLT.
        doReset();
        applyStimulus(8'h21, 8'h00, 1'b1, 3'd0, 2);
        applyStimulus(8'h03, 8'h01, 1'b1, 3'd1, 2);
        applyStimulus(8'h00, 8'h00, 1'b1, 3'd2, 0);
        waitDone("basic", 3, 1'b0);

        // Back-to-back strobes: the third byte lands in word 0's WRITE cycle.
        doReset();
        applyStimulus(8'h05, 8'h12, 1'b1, 3'd0, 0);
        applyStimulus(8'h07, 8'h34, 1'b1, 3'd1, 0);
        applyStimulus(8'h00, 8'h00, 1'b1, 3'd2, 0);
        waitDone("b2b", 3, 1'b0);

        // Fill all 8 addresses with non-HLT words, then try a 9th in DONE.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h01, 8'(8'h10 + i), 1'b1, 3'(i), 1);
        end
        waitDone("full", 8, 1'b1);
        applyStimulus(8'h01, 8'h99, 1'b0, 3'd0, 1);
        applyStimulus(8'h00, 8'h00, 1'b0, 3'd0, 1);
        repeat (5) @(negedge clk);
        checkOutput("done_hold_addr",   32'(pm_addr),    7);
        checkOutput("done_hold_count",  32'(word_count), 8);
        checkOutput("done_hold_cpu_en", 32'(cpu_en),     1);

        // Clear after the first byte of word 2; the pending byte must vanish.
        doReset();
        applyStimulus(8'h21, 8'h00, 1'b1, 3'd0, 1);
        applyStimulus(8'h03, 8'h01, 1'b1, 3'd1, 1);
        sendByte(8'h55, 1);
        checkOutput("preclear_queue_empty", 32'(expQueue.size()), 0);
        doReset();
        checkIdle("mid_clear");
        applyStimulus(8'h40, 8'h12, 1'b1, 3'd0, 1);
        waitDone("reload", 1, 1'b0);

        // Odd trailing byte never completes a word.
        doReset();
        sendByte(8'h00, 20);
        checkOutput("odd_byte_cpu_en", 32'(cpu_en),     0);
        checkOutput("odd_byte_count",  32'(word_count), 0);

        repeat (3) @(negedge clk);
        checkOutput("final_queue_empty", 32'(expQueue.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
